brick_health_ctrl: RTL and testbench

Owns the brick field state: a health value for every brick in the grid, and the count of bricks still standing. It sits directly upstream of the brick draw stage. After reset it paints the whole field once. During play it turns ball-collision reports into health decrements, "hit" acknowledgements back to the ball logic, and one redraw request per changed brick to the draw stage.

---
 rtl/brick_pkg.sv | 28 ++
 rtl/brick_locate.sv | 28 ++
 rtl/brick_health_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_brick_health_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/brick_pkg.sv
// Shared brick-field geometry, state encoding and health type for the brick pipeline.
package brick_pkg;

  localparam int unsigned COLS         = 10;
  localparam int unsigned ROWS         = 4;
  localparam int unsigned BRICK_W_LOG2 = 5;
  localparam int unsigned BRICK_H_LOG2 = 4;
  localparam int unsigned ORIGIN_X     = 0;
  localparam int unsigned ORIGIN_Y     = 32;

  localparam int unsigned NUM_BRICKS = COLS * ROWS;
  localparam int unsigned IDX_W      = $clog2(NUM_BRICKS);
  localparam int unsigned COL_W      = $clog2(COLS);
  localparam int unsigned ROW_W      = $clog2(ROWS);

  typedef logic [1:0] health_t;

  typedef enum logic [2:0] {
    StInitIssue,
    StInitWait,
    StIdle,
    StCheck1,
    StWait1,
    StCheck2,
    StWait2
  } state_e;

endpackage

// File: rtl/brick_locate.sv
// Combinational pixel-to-brick converter: grid index, in-grid flag and brick top-left corner.
module brick_locate
  import brick_pkg::*;
(
  input  logic [9:0]       x,
  input  logic [9:0]       y,
  output logic [IDX_W-1:0] idx,
  output logic             in_grid,
  output logic [9:0]       brick_x,
  output logic [9:0]       brick_y
);

  logic [10:0] dx, dy;
  logic [9:0]  col, row;

  always_comb begin
    // Extra MSB flags coordinates left of / above the grid origin.
    dx      = {1'b0, x} - 11'(ORIGIN_X);
    dy      = {1'b0, y} - 11'(ORIGIN_Y);
    col     = dx[9:0] >> BRICK_W_LOG2;
    row     = dy[9:0] >> BRICK_H_LOG2;
    in_grid = !dx[10] && !dy[10] && (col < 10'(COLS)) && (row < 10'(ROWS));
    idx     = IDX_W'(row * 10'(COLS) + col);
    brick_x = 10'(ORIGIN_X) + (col << BRICK_W_LOG2);
    brick_y = 10'(ORIGIN_Y) + (row << BRICK_H_LOG2);
  end

endmodule

// File: rtl/brick_health_ctrl.sv
// Brick field owner: initial paint, collision-driven health decrements, hit pulses and
// one redraw request per changed brick.
module brick_health_ctrl
  import brick_pkg::*;
#(
  parameter int unsigned INIT_HEALTH = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] col_x1,
  input  logic [9:0] col_y1,
  input  logic       collided_1,
  input  logic [9:0] col_x2,
  input  logic [9:0] col_y2,
  input  logic       collided_2,
  output logic       hit_1,
  output logic       hit_2,
  output logic       draw_start,
  output logic [9:0] brick_x,
  output logic [9:0] brick_y,
  output logic [1:0] health,
  input  logic       draw_done,
  output logic [5:0] bricks_left,
  output logic       all_clear
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [COL_W-1:0] init_col_q, init_col_d;
  logic [ROW_W-1:0] init_row_q, init_row_d;
  health_t          brick_hp_q [NUM_BRICKS];
  logic [5:0]       bricks_left_q;

  logic             pend_1_q, pend_1_d, pend_2_q, pend_2_d;
  logic [9:0]       px_1_q, py_1_q, px_2_q, py_2_q;
  logic             init_st, cap_1, cap_2;

  logic             hit_1_q, hit_1_d, hit_2_q, hit_2_d;
  logic             draw_start_q, draw_start_d;
  logic [9:0]       brick_x_q, brick_x_d, brick_y_q, brick_y_d;
  health_t          health_out_q, health_out_d;

  logic [9:0]       loc_x, loc_y, loc_bx, loc_by;
  logic [IDX_W-1:0] loc_idx;
  logic             loc_in_grid;
  health_t          cur_h;
  logic             wr_en;

  assign loc_x = (state_q == StCheck2) ? px_2_q : px_1_q;
  assign loc_y = (state_q == StCheck2) ? py_2_q : py_1_q;

  brick_locate u_locate (
    .x       (loc_x),
    .y       (loc_y),
    .idx     (loc_idx),
    .in_grid (loc_in_grid),
    .brick_x (loc_bx),
    .brick_y (loc_by)
  );

  assign cur_h = brick_hp_q[loc_idx];

  always_comb begin
    init_st = (state_q == StInitIssue) || (state_q == StInitWait);
    cap_1   = collided_1 && !pend_1_q && !init_st;
    cap_2   = collided_2 && !pend_2_q && !init_st;
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    init_col_d   = init_col_q;
    init_row_d   = init_row_q;
    hit_1_d      = 1'b0;
    hit_2_d      = 1'b0;
    draw_start_d = 1'b0;
    brick_x_d    = brick_x_q;
    brick_y_d    = brick_y_q;
    health_out_d = health_out_q;
    wr_en        = 1'b0;

    case (state_q)
      StInitIssue: begin
        draw_start_d = 1'b1;
        brick_x_d    = 10'(ORIGIN_X) + (10'(init_col_q) << BRICK_W_LOG2);
        brick_y_d    = 10'(ORIGIN_Y) + (10'(init_row_q) << BRICK_H_LOG2);
        health_out_d = health_t'(INIT_HEALTH);
        state_d      = StInitWait;
      end
      StInitWait: begin
        if (draw_done) begin
          if (idx_q == IDX_W'(NUM_BRICKS - 1)) begin
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = StInitIssue;
            if (init_col_q == COL_W'(COLS - 1)) begin
              init_col_d = '0;
              init_row_d = init_row_q + ROW_W'(1);
            end else begin
              init_col_d = init_col_q + COL_W'(1);
            end
          end
        end
      end
      StIdle: begin
        if (pend_1_q || collided_1) begin
          state_d = StCheck1;
        end else if (pend_2_q || collided_2) begin
          state_d = StCheck2;
        end
      end
      StCheck1, StCheck2: begin
        if (loc_in_grid && (cur_h != 2'd0)) begin
          wr_en        = 1'b1;
          hit_1_d      = (state_q == StCheck1);
          hit_2_d      = (state_q == StCheck2);
          draw_start_d = 1'b1;
          brick_x_d    = loc_bx;
          brick_y_d    = loc_by;
          health_out_d = cur_h - 2'd1;
          state_d      = (state_q == StCheck1) ? StWait1 : StWait2;
        end else begin
          state_d = StIdle;
        end
      end
      StWait1, StWait2: begin
        if (draw_done) state_d = StIdle;
      end
      default: state_d = StInitIssue;
    endcase

    // A latch set in the same cycle its check state is entered is consumed by that check.
    if (state_d == StCheck1 && state_q != StCheck1) begin
      pend_1_d = 1'b0;
    end else begin
      pend_1_d = pend_1_q | cap_1;
    end
    if (state_d == StCheck2 && state_q != StCheck2) begin
      pend_2_d = 1'b0;
    end else begin
      pend_2_d = pend_2_q | cap_2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StInitIssue;
      idx_q        <= '0;
      init_col_q   <= '0;
      init_row_q   <= '0;
      pend_1_q     <= 1'b0;
      pend_2_q     <= 1'b0;
      px_1_q       <= '0;
      py_1_q       <= '0;
      px_2_q       <= '0;
      py_2_q       <= '0;
      hit_1_q      <= 1'b0;
      hit_2_q      <= 1'b0;
      draw_start_q <= 1'b0;
      brick_x_q    <= '0;
      brick_y_q    <= '0;
      health_out_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      init_col_q   <= init_col_d;
      init_row_q   <= init_row_d;
      pend_1_q     <= pend_1_d;
      pend_2_q     <= pend_2_d;
      hit_1_q      <= hit_1_d;
      hit_2_q      <= hit_2_d;
      draw_start_q <= draw_start_d;
      brick_x_q    <= brick_x_d;
      brick_y_q    <= brick_y_d;
      health_out_q <= health_out_d;
      if (cap_1) begin
        px_1_q <= col_x1;
        py_1_q <= col_y1;
      end
      if (cap_2) begin
        px_2_q <= col_x2;
        py_2_q <= col_y2;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_BRICKS); i++) begin
        brick_hp_q[i] <= health_t'(INIT_HEALTH);
      end
      bricks_left_q <= 6'(NUM_BRICKS);
    end else if (wr_en) begin
      brick_hp_q[loc_idx] <= cur_h - 2'd1;
      if (cur_h == 2'd1 && bricks_left_q != 6'd0) begin
        bricks_left_q <= bricks_left_q - 6'd1;
      end
    end
  end

  assign hit_1       = hit_1_q;
  assign hit_2       = hit_2_q;
  assign draw_start  = draw_start_q;
  assign brick_x     = brick_x_q;
  assign brick_y     = brick_y_q;
  assign health      = health_out_q;
  assign bricks_left = bricks_left_q;
  assign all_clear   = (bricks_left_q == 6'd0);

endmodule

// File: tb/tb_brick_health_ctrl.sv
// Directed bench for brick_health_ctrl with a scoreboard of expected redraw requests.
module tb_brick_health_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] col_x1 = '0, col_y1 = '0, col_x2 = '0, col_y2 = '0;
  logic       collided_1 = 1'b0, collided_2 = 1'b0;
  logic       draw_done = 1'b0;
  logic       hit_1, hit_2, draw_start, all_clear;
  logic [9:0] brick_x, brick_y;
  logic [1:0] health;
  logic [5:0] bricks_left;

  brick_health_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .col_x1      (col_x1),
    .col_y1      (col_y1),
    .collided_1  (collided_1),
    .col_x2      (col_x2),
    .col_y2      (col_y2),
    .collided_2  (collided_2),
    .hit_1       (hit_1),
    .hit_2       (hit_2),
    .draw_start  (draw_start),
    .brick_x     (brick_x),
    .brick_y     (brick_y),
    .health      (health),
    .draw_done   (draw_done),
    .bricks_left (bricks_left),
    .all_clear   (all_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int h;
    bit h1;
    bit h2;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   draws_seen = 0;
  int   draws_exp = 0;
  int   hmod[40];
  int   blmod = 40;
  bit   auto_done = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Draw stage stand-in: acknowledges each draw a few cycles later.
  initial forever begin
    @(negedge clk);
    if (!reset && draw_start && auto_done) begin
      repeat (2) @(negedge clk);
      draw_done = 1'b1;
      @(negedge clk);
      draw_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (draw_start) begin
        draws_seen++;
        if (sb.size() == 0) begin
          check("unexpected_draw", 32'(draw_start), 32'd0);
        end else begin
          e = sb.pop_front();
          check("draw_x", 32'(brick_x), e.x);
          check("draw_y", 32'(brick_y), e.y);
          check("draw_health", 32'(health), e.h);
          check("draw_hit_1", 32'(hit_1), 32'(e.h1));
          check("draw_hit_2", 32'(hit_2), 32'(e.h2));
        end
      end else begin
        if (hit_1) check("stray_hit_1", 32'(hit_1), 32'd0);
        if (hit_2) check("stray_hit_2", 32'(hit_2), 32'd0);
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 40; i++) hmod[i] = 3;
    blmod = 40;
    sb.delete();
    for (int i = 0; i < 40; i++) begin
      sb.push_back('{(i % 10) * 32, 32 + (i / 10) * 16, 3, 1'b0, 1'b0});
      draws_exp++;
    end
  endtask

  task automatic model(input int port, input int x, input int y);
    int col, row, idx;
    if (x >= 0 && y >= 32 && x / 32 < 10 && (y - 32) / 16 < 4) begin
      col = x / 32;
      row = (y - 32) / 16;
      idx = row * 10 + col;
      if (hmod[idx] > 0) begin
        hmod[idx]--;
        if (hmod[idx] == 0) blmod--;
        sb.push_back('{col * 32, 32 + row * 16, hmod[idx], port == 1, port == 2});
        draws_exp++;
      end
    end
  endtask

  task automatic pulse(input bit p1, input int x1, input int y1,
                       input bit p2, input int x2, input int y2);
    @(negedge clk);
    col_x1 = 10'(x1); col_y1 = 10'(y1); collided_1 = p1;
    col_x2 = 10'(x2); col_y2 = 10'(y2); collided_2 = p2;
    @(negedge clk);
    collided_1 = 1'b0;
    collided_2 = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("sb_drained", sb.size(), 0);
    repeat (8) @(negedge clk);
    check("draw_count", draws_seen, draws_exp);
    check("bricks_left", 32'(bricks_left), blmod);
    check("all_clear", 32'(all_clear), 32'(blmod == 0));
  endtask

  task automatic report(input int port, input int x, input int y);
    model(port, x, y);
    if (port == 1) pulse(1'b1, x, y, 1'b0, 0, 0);
    else           pulse(1'b0, 0, 0, 1'b1, x, y);
    wait_idle();
  endtask

  initial begin
    int n;
    // Power-on reset and full initial paint.
    #1 reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_draw_start", 32'(draw_start), 0);
    check("rst_hit_1", 32'(hit_1), 0);
    check("rst_brick_x", 32'(brick_x), 0);
    check("rst_health", 32'(health), 0);
    check("rst_bricks_left", 32'(bricks_left), 40);
    reset = 1'b0;
    wait_idle();

    // Single hit with exact latency check.
    model(1, 40, 35);
    @(negedge clk);
    col_x1 = 10'd40; col_y1 = 10'd35; collided_1 = 1'b1;
    @(negedge clk);
    collided_1 = 1'b0;
    check("lat_t1_hit_1", 32'(hit_1), 0);
    check("lat_t1_draw", 32'(draw_start), 0);
    @(negedge clk);
    check("lat_t2_hit_1", 32'(hit_1), 1);
    check("lat_t2_draw", 32'(draw_start), 1);
    @(negedge clk);
    check("lat_t3_hit_1", 32'(hit_1), 0);
    check("lat_t3_draw", 32'(draw_start), 0);
    wait_idle();

    // Wear one brick down to zero, then one more report.
    for (int k = 0; k < 4; k++) report(1, 5, 50);
    check("worn_bricks_left", 32'(bricks_left), 39);

    // Same-cycle reports on both ports: port 1 first.
    model(1, 5, 33);
    model(2, 300, 90);
    pulse(1'b1, 5, 33, 1'b1, 300, 90);
    wait_idle();

    // Out-of-grid reports.
    report(1, 330, 40);
    report(2, 10, 10);
    report(1, 10, 100);

    // Reset while a hit's redraw is outstanding.
    auto_done = 1'b0;
    model(1, 40, 35);
    pulse(1'b1, 40, 35, 1'b0, 0, 0);
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wait1_draw_seen", sb.size(), 0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_brick_x", 32'(brick_x), 0);
    check("midrst_brick_y", 32'(brick_y), 0);
    check("midrst_health", 32'(health), 0);
    check("midrst_bricks_left", 32'(bricks_left), 40);
    model_reset();
    auto_done = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_idle();

    // Clear the entire field, alternating ports.
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 3; k++) begin
        report((k % 2) + 1, (i % 10) * 32 + 7, 32 + (i / 10) * 16 + 3);
      end
    end
    check("clear_bricks_left", 32'(bricks_left), 0);
    check("clear_all_clear", 32'(all_clear), 1);
    report(2, 100, 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
